inv_sub_bytes: RTL and testbench
================================

// Module: inv_sub_bytes
// PURPOSE
// - AES-128 InvSubBytes stage: applies the FIPS-197 inverse S-box independently to all 16 bytes of a 128-bit state.
// - Sits in the decryption round datapath between InvShiftRows and AddRoundKey.
// - Single registered stage: the result appears one clock after the input is sampled.
// PARAMETERS
// - none. Width is fixed at 128 bits: 16 lanes of 8 bits each.
// PORTS
// - clk              in   1    rising-edge clock (one clock domain)
// - rst_n            in   1    asynchronous, active-low reset
// - IN_DATA          in   128  input state; byte k = IN_DATA[8k+7:8k]
// - INV_SB_DATA_OUT  out  128  registered inverse-S-box result
// - IN_VALID         in   1    present only with INV_SB_VALID_EN
// - OUT_VALID        out  1    present only with INV_SB_VALID_EN
// BEHAVIOUR
// - Reset: rst_n low clears INV_SB_DATA_OUT (and OUT_VALID) to 0 immediately, with no clock.
// - Reset mid-operation: the data in flight is discarded.
// - Release of rst_n is synchronised by the caller. The first capture happens on the first rising clk edge with rst_n high.
// - Per lane: INV_SB_DATA_OUT[8k+7:8k] <= InvSBox(IN_DATA[8k+7:8k]) at each rising clk edge, for k = 0..15.
// - InvSBox is the full 256-entry FIPS-197 table. Anchors: 00->52, 01->09, 63->00, 7c->01, ff->7d, 69->e4, 5a->46.
// - InvSBox is a combinational lookup, implemented as a case ROM or function. No arithmetic is computed at run time.
// - Latency: exactly 1 cycle, from IN_DATA sampled at edge N to output valid after edge N.
// - Throughput: one new state per cycle. No stall or backpressure.
// - All 16 lanes are identical and independent. No byte reordering.
// - The output is constant between clock edges. IN_DATA glitches between edges have no effect.
// - The design is combinational lookup plus registers only. No FSM.
// CONFIGURATION
// - Macro INV_SB_VALID_EN.
// - Defined:
//   - Adds ports IN_VALID and OUT_VALID.
//   - The data register loads only on edges where IN_VALID=1 and otherwise holds its value.
//   - OUT_VALID <= IN_VALID every edge; OUT_VALID resets to 0.
// - Undefined:
//   - No valid ports.
//   - The data register loads on every edge.
// TESTING
// - Reset: assert rst_n=0 with a nonzero output. INV_SB_DATA_OUT = 0 before the next clk edge.
// - Vector: IN_DATA=69c4e0d86a7b0430d8cdb78070b4c55a -> one edge later INV_SB_DATA_OUT=e488a02d580330082d80203ad0c60746.
// - Edge values:
//   - IN_DATA=all 00 -> all 52.
//   - IN_DATA=all ff -> all 7d.
//   - IN_DATA=all 63 -> all 00.
// - Exhaustive: walk every byte value 00..ff in all 16 lanes. Compare against InvSBox(SBox(x))=x round trip; no mismatch.
// - Back-to-back: a new vector every cycle. Each output matches the input from exactly 1 cycle earlier.
// - INV_SB_VALID_EN:
//   - IN_VALID=0 with changing IN_DATA -> output holds its value and OUT_VALID=0.
//   - IN_VALID=1 -> the output updates and OUT_VALID=1 one cycle later.

Source files
------------

// File: rtl/inv_sub_bytes.sv
// AES-128 InvSubBytes: 16 parallel inverse S-box lookups, one register stage.
// Define INV_SB_VALID_EN to add IN_VALID/OUT_VALID and a load-enabled data register.
module inv_sub_bytes (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] IN_DATA,
`ifdef INV_SB_VALID_EN
  input  logic         IN_VALID,
  output logic         OUT_VALID,
`endif
  output logic [127:0] INV_SB_DATA_OUT
);

  // Row r of the table holds InvSBox(16r .. 16r+15), entry 0 is the MSB byte.
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX[x];
  endfunction

  logic [127:0] w_sub;
  logic [127:0] r_data;

  always_comb begin
    w_sub = '0;
    for (int k = 0; k < 16; k++) begin
      w_sub[8*k +: 8] = inv_sbox(IN_DATA[8*k +: 8]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else begin
`ifdef INV_SB_VALID_EN
      if (IN_VALID) r_data <= w_sub;
`else
      r_data <= w_sub;
`endif
    end
  end

`ifdef INV_SB_VALID_EN
  logic r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_valid <= 1'b0;
    else        r_valid <= IN_VALID;
  end

  assign OUT_VALID = r_valid;
`endif

  assign INV_SB_DATA_OUT = r_data;

endmodule

// File: tb/tb_inv_sub_bytes.sv
// Scoreboard bench for inv_sub_bytes: directed vectors plus a
// forward-S-box round trip over every byte value in every lane.
module tb_inv_sub_bytes;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [127:0] V_IN  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] V_OUT = 128'he488a02d580330082d80203ad0c60746;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] in_data = '0;
  logic [127:0] out_data;
  logic         tb_vld = 1'b0;
  logic [127:0] last_e = '0;

  int checks = 0;
  int failures = 0;
  logic [127:0] exp_q[$];

  always #5 clk = ~clk;

`ifdef INV_SB_VALID_EN
  logic out_vld;
  inv_sub_bytes dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .IN_DATA        (in_data),
    .IN_VALID       (tb_vld),
    .OUT_VALID      (out_vld),
    .INV_SB_DATA_OUT(out_data)
  );
`else
  inv_sub_bytes dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .IN_DATA        (in_data),
    .INV_SB_DATA_OUT(out_data)
  );
`endif

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [127:0] d, input logic [127:0] e);
    @(negedge clk);
    in_data = d;
    tb_vld  = 1'b1;
    exp_q.push_back(e);
    last_e = e;
  endtask

  // Monitor: one result is owed for every edge that saw valid stimulus.
  always @(posedge clk) begin
    logic         pend;
    logic [127:0] e;
    pend = tb_vld && rst_n;
    #1;
`ifdef INV_SB_VALID_EN
    checks++;
    if (out_vld !== pend) begin
      failures++;
      $display("FAIL out_valid actual=%b required=%b", out_vld, pend);
    end
`endif
    if (pend) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow actual=empty required=entry");
      end else begin
        e = exp_q.pop_front();
        chk("sb_data", out_data, e);
      end
    end
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_state", out_data, 128'h0);
    rst_n = 1'b1;

    issue(V_IN, V_OUT);
    issue({16{8'h00}}, {16{8'h52}});
    issue({16{8'hff}}, {16{8'h7d}});
    issue({16{8'h63}}, {16{8'h00}});
    @(negedge clk);
    tb_vld = 1'b0;
    repeat (2) @(negedge clk);

    @(posedge clk);
    #2 in_data = 128'h0123456789abcdeffedcba9876543210;
    #1 in_data = {16{8'h63}};
    @(negedge clk);
    chk("glitch_hold", out_data, 128'h0);

    issue({16{8'h00}}, {16{8'h52}});
    @(negedge clk);
    tb_vld = 1'b0;
    @(negedge clk);
    chk("pre_reset", out_data, {16{8'h52}});
    #1 rst_n = 1'b0;
    #1 chk("reset_async", out_data, 128'h0);
    @(negedge clk);
    in_data = V_IN;
    tb_vld  = 1'b1;
    @(posedge clk);
    #1 chk("inflight_discard", out_data, 128'h0);
    @(negedge clk);
    rst_n  = 1'b1;
    tb_vld = 1'b0;

    for (int x = 0; x < 256; x++) begin
      logic [127:0] d;
      logic [127:0] e;
      logic [7:0]   b;
      for (int k = 0; k < 16; k++) begin
        b = 8'(x + k);
        d[8*k +: 8] = SBOX[b];
        e[8*k +: 8] = b;
      end
      issue(d, e);
    end

`ifdef INV_SB_VALID_EN
    @(negedge clk);
    tb_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      chk("valid_hold", out_data, last_e);
    end
    issue(V_IN, V_OUT);
`endif

    @(negedge clk);
    tb_vld = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
